ysyx_22040759_axi_rd_master: RTL and testbench
==============================================

# ysyx_22040759_axi_rd_master

Read-channel responder that serves the single core-side read port driven by the IF/MEM read arbiter (`rd_addr_valid`, `rd_addr`, `rd_size`, `rd_data_valid`, `rd_data`). It converts each core request into one single-beat AXI4 read: an AR handshake followed by an R handshake. It returns the beat, optionally byte-aligned, with a one-cycle `rd_data_valid_o` pulse. At most one transaction is in flight, and the block sits between the arbiter and the SoC AXI interconnect.

## Interface
- `AXI_ID_W`, default 4: width of the AXI ID fields.
- `AXI_ID`, default 0: constant ARID value.
- `clk`  in  1  sole clock; all logic samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_addr_valid_i`  in  1  request pending; held until `rd_data_valid_o`.
- `rd_addr_i`  in  64  byte address.
- `rd_size_i`  in  2  00 byte, 01 half, 10 word, 11 dword.
- `rd_data_valid_o`  out  1  one-cycle completion pulse.
- `rd_data_o`  out  64  read data, valid only while `rd_data_valid_o`=1.
- `rd_err_o`  out  1  RRESP was not OKAY; valid only with `rd_data_valid_o`.
- `axi_ar_valid_o`  out  1  AR valid.
- `axi_ar_ready_i`  in  1  AR ready.
- `axi_ar_addr_o`  out  64  ARADDR.
- `axi_ar_id_o`  out  `AXI_ID_W`  ARID.
- `axi_ar_len_o`  out  8  ARLEN.
- `axi_ar_size_o`  out  3  ARSIZE.
- `axi_ar_burst_o`  out  2  ARBURST.
- `axi_r_valid_i`  in  1  R valid.
- `axi_r_ready_o`  out  1  R ready.
- `axi_r_data_i`  in  64  RDATA.
- `axi_r_resp_i`  in  2  RRESP.
- `axi_r_last_i`  in  1  RLAST.
- `axi_r_id_i`  in  `AXI_ID_W`  RID.

## Operation
- FSM has four states: IDLE, AR, R, RESP (one-hot).
- **IDLE:** when `rd_addr_valid_i`=1, latch `rd_addr_i` and `rd_size_i`, then go to AR. Otherwise stay in IDLE.
- **AR:** `axi_ar_valid_o`=1. ARADDR is the latched address, ARSIZE={1'b0,size}, ARLEN=0, ARBURST=INCR (2'b01), ARID=`AXI_ID`. When `axi_ar_ready_i`=1, go to R.
- **R:** `axi_r_ready_o`=1. When `axi_r_valid_i`=1, register the data and the error flag (`rd_err` = RRESP≠2'b00), then go to RESP.
  - RLAST and RID are not checked; only one transaction is ever outstanding.
- **RESP:** `rd_data_valid_o`=1 for exactly one cycle, then go to IDLE.
- AR payload is stable while `axi_ar_valid_o`=1. Latched request fields ignore changes on `rd_*_i` after acceptance.
- The requester must drop or replace `rd_addr_valid_i` in the cycle after the pulse. A request still asserted in IDLE is treated as a new request.
- Reset values: FSM=IDLE, and every output is 0, except `axi_ar_len_o`=0 and `axi_ar_burst_o`=2'b01, which are constants.

## Timing
- Best case: request seen at cycle 0 → `axi_ar_valid_o` at cycle 1 → `axi_r_ready_o` at cycle 2 → `rd_data_valid_o` at cycle 3. Minimum latency is 3 cycles.
- Each cycle `axi_ar_ready_i` or `axi_r_valid_i` is held low adds one cycle.
- The earliest next acceptance is in the IDLE cycle after RESP, giving a minimum spacing of 4 cycles between requests.
- `rst` in any state returns the FSM to IDLE on the next edge and clears all outputs. An AXI transaction in flight is abandoned; reset is system-wide.
- `rd_data_o` and `rd_err_o` are registered outputs. No input-to-output combinational path exists.

## Configuration
- Macro: `YSYX_22040759_RD_ALIGN_EN`.
- **Defined:** `rd_data_o` = RDATA >> (addr[2:0]*8), masked to 1/2/4/8 bytes per size and zero-extended.
  - Bytes shifted past the top of the beat read as 0.
- **Undefined:** `rd_data_o` = raw RDATA beat; the core extracts the bytes.

## Structure
- Shared define file `ysyx_22040759_define.v` holds:
  - the size encodings;
  - the AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00;
  - the FSM state encodings.
- Sub-module `ysyx_22040759_rd_align` is the combinational (data, addr[2:0], size) → aligned data extractor. It is instantiated only under the macro.

## Test plan
- dword read at 0x8000_0000, AR/R ready immediately, RDATA=0x1122334455667788 → `rd_data_valid_o` at cycle 3, data 0x1122334455667788, `rd_err_o`=0.
- byte read at 0x8000_0003, RDATA=0x1122334455667788, ALIGN_EN defined → `rd_data_o`=0x55. With the macro undefined → raw beat.
- `axi_ar_ready_i` low for 5 cycles, then `axi_r_valid_i` low for 3 cycles → ARADDR/ARSIZE stable throughout, pulse at cycle 11, exactly one pulse.
- RRESP=2'b10 on a word read → `rd_err_o`=1 together with `rd_data_valid_o`.
- `rst` asserted while in R → next cycle IDLE, all outputs 0, and a new request proceeds normally.
- `rd_addr_valid_i` held high with the address changed after the pulse → two distinct AR transactions with a gap of exactly 1 idle cycle.

Source files
------------

// File: rtl/ysyx_22040759_axi_rd_master_pkg.sv
// Shared definitions for the AXI read master: size encodings, AXI constants and FSM states.
// Plays the role of the ysyx_22040759_define file for this slice.
package ysyx_22040759_axi_rd_master_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AR   = 4'b0010,
    ST_R    = 4'b0100,
    ST_RESP = 4'b1000
  } rd_state_e;

endpackage

// File: rtl/ysyx_22040759_rd_align.sv
// Combinational beat extractor: shifts the requested bytes down to bit 0 and
// zero-extends them to 64 bits according to the access size.
module ysyx_22040759_rd_align
  import ysyx_22040759_axi_rd_master_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  output logic [63:0] aligned
);

  logic [63:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    aligned = '0;
    case (size)
      SIZE_B:  aligned = {56'd0, shifted[7:0]};
      SIZE_H:  aligned = {48'd0, shifted[15:0]};
      SIZE_W:  aligned = {32'd0, shifted[31:0]};
      default: aligned = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_axi_rd_master.sv
// Single-outstanding AXI4 read master: one core request becomes one AR + one R beat.
// Define YSYX_22040759_RD_ALIGN_EN to return byte-aligned, size-masked data instead of the raw beat.
module ysyx_22040759_axi_rd_master
  import ysyx_22040759_axi_rd_master_pkg::*;
#(
  parameter int          AXI_ID_W = 4,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_addr_valid_i,
  input  logic [63:0]         rd_addr_i,
  input  logic [1:0]          rd_size_i,
  output logic                rd_data_valid_o,
  output logic [63:0]         rd_data_o,
  output logic                rd_err_o,
  output logic                axi_ar_valid_o,
  input  logic                axi_ar_ready_i,
  output logic [63:0]         axi_ar_addr_o,
  output logic [AXI_ID_W-1:0] axi_ar_id_o,
  output logic [7:0]          axi_ar_len_o,
  output logic [2:0]          axi_ar_size_o,
  output logic [1:0]          axi_ar_burst_o,
  input  logic                axi_r_valid_i,
  output logic                axi_r_ready_o,
  input  logic [63:0]         axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  input  logic                axi_r_last_i,
  input  logic [AXI_ID_W-1:0] axi_r_id_i
);

  rd_state_e   state_q, state_d;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] rd_data_q;
  logic        rd_err_q;
  logic [63:0] beat;

  // Single beat, single ID outstanding: RLAST and RID carry no information here.
  logic unused_r_sideband;
  assign unused_r_sideband = ^{axi_r_last_i, axi_r_id_i};

`ifdef YSYX_22040759_RD_ALIGN_EN
  ysyx_22040759_rd_align u_rd_align (
    .data    (axi_r_data_i),
    .offset  (addr_q[2:0]),
    .size    (size_q),
    .aligned (beat)
  );
`else
  assign beat = axi_r_data_i;
`endif

  always_comb begin
    state_d         = state_q;
    axi_ar_valid_o  = 1'b0;
    axi_r_ready_o   = 1'b0;
    rd_data_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: if (rd_addr_valid_i) state_d = ST_AR;
      ST_AR: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) state_d = ST_R;
      end
      ST_R: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        rd_data_valid_o = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields latch only on acceptance, so the AR payload cannot move while AR is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && rd_addr_valid_i) begin
        addr_q <= rd_addr_i;
        size_q <= rd_size_i;
      end
      if (state_q == ST_R && axi_r_valid_i) begin
        rd_data_q <= beat;
        rd_err_q  <= (axi_r_resp_i != RESP_OKAY);
      end
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_err_o       = rd_err_q;
  assign axi_ar_addr_o  = addr_q;
  assign axi_ar_size_o  = {1'b0, size_q};
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_burst_o = BURST_INCR;
  assign axi_ar_id_o    = AXI_ID_W'(AXI_ID);

endmodule

// File: tb/tb_ysyx_22040759_axi_rd_master.sv
// Directed self-checking bench for the AXI read master; expectations follow the
// YSYX_22040759_RD_ALIGN_EN setting of the build.
module tb_ysyx_22040759_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_addr_valid;
  logic [63:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_data_valid;
  logic [63:0] rd_data;
  logic        rd_err;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] BEAT = 64'h1122334455667788;

  always #5 clk = ~clk;

  ysyx_22040759_axi_rd_master dut (
    .clk             (clk),
    .rst             (rst),
    .rd_addr_valid_i (rd_addr_valid),
    .rd_addr_i       (rd_addr),
    .rd_size_i       (rd_size),
    .rd_data_valid_o (rd_data_valid),
    .rd_data_o       (rd_data),
    .rd_err_o        (rd_err),
    .axi_ar_valid_o  (ar_valid),
    .axi_ar_ready_i  (ar_ready),
    .axi_ar_addr_o   (ar_addr),
    .axi_ar_id_o     (ar_id),
    .axi_ar_len_o    (ar_len),
    .axi_ar_size_o   (ar_size),
    .axi_ar_burst_o  (ar_burst),
    .axi_r_valid_i   (r_valid),
    .axi_r_ready_o   (r_ready),
    .axi_r_data_i    (r_data),
    .axi_r_resp_i    (r_resp),
    .axi_r_last_i    (r_last),
    .axi_r_id_i      (r_id)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Full transaction: request driven in cycle 0, AR ready withheld for arw AR cycles,
  // R valid withheld for rw R cycles; rd_* inputs are scrambled once accepted.
  task automatic do_req(input string tag, input logic [63:0] a, input logic [1:0] s,
                        input logic [63:0] rdat, input logic [1:0] rresp,
                        input int arw, input int rw,
                        input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
    int arc = 0;
    int rc = 0;
    int pulses = 0;
    int lat = -1;
    logic [63:0] got_d = '0;
    logic got_e = 1'b0;
    rd_addr_valid = 1'b1; rd_addr = a; rd_size = s;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = rdat; r_resp = rresp;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (ar_valid) begin
        chk({tag, "_araddr"}, ar_addr, a);
        chk({tag, "_arsize"}, 64'(ar_size), 64'({1'b0, s}));
        if (arc == 0) begin
          chk({tag, "_arlen"}, 64'(ar_len), 64'd0);
          chk({tag, "_arburst"}, 64'(ar_burst), 64'd1);
          chk({tag, "_arid"}, 64'(ar_id), 64'd0);
        end
        ar_ready = (arc >= arw);
        arc++;
        rd_addr = ~a; rd_size = ~s;
      end else begin
        ar_ready = 1'b0;
      end
      if (r_ready) begin
        r_valid = (rc >= rw);
        rc++;
      end else begin
        r_valid = 1'b0;
      end
      if (rd_data_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc; got_d = rd_data; got_e = rd_err;
        end
        rd_addr_valid = 1'b0;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_data"}, got_d, exp_data);
    chk({tag, "_err"}, 64'(got_e), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] exp_b, exp_h, exp_w, exp_e;
    int got_rr;
    logic [7:0] ar_tab;
    logic [7:0] dv_tab;
`ifdef YSYX_22040759_RD_ALIGN_EN
    exp_b = 64'h55; exp_h = 64'h1122; exp_w = 64'h1122; exp_e = 64'h11223344;
`else
    exp_b = BEAT; exp_h = BEAT; exp_w = BEAT; exp_e = BEAT;
`endif
    rst = 1'b1; rd_addr_valid = 1'b0; rd_addr = '0; rd_size = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b1; r_id = '0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", 64'(ar_valid), 64'd0);
    chk("rst_rready", 64'(r_ready), 64'd0);
    chk("rst_dvalid", 64'(rd_data_valid), 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_err", 64'(rd_err), 64'd0);
    chk("rst_araddr", ar_addr, 64'd0);
    chk("rst_arlen", 64'(ar_len), 64'd0);
    chk("rst_arburst", 64'(ar_burst), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    do_req("dword", 64'h8000_0000, 2'b11, BEAT, 2'b00, 0, 0, BEAT, 1'b0, 3);
    do_req("byte3", 64'h8000_0003, 2'b00, BEAT, 2'b00, 0, 0, exp_b, 1'b0, 3);
    do_req("half6", 64'h8000_0006, 2'b01, BEAT, 2'b00, 0, 0, exp_h, 1'b0, 3);
    do_req("word6", 64'h8000_0006, 2'b10, BEAT, 2'b00, 0, 0, exp_w, 1'b0, 3);
    do_req("stall", 64'h8000_0010, 2'b11, BEAT, 2'b00, 5, 3, BEAT, 1'b0, 11);
    do_req("slverr", 64'h8000_0004, 2'b10, BEAT, 2'b10, 0, 0, exp_e, 1'b1, 3);

    // Reset while waiting in R.
    rd_addr_valid = 1'b1; rd_addr = 64'h8000_0020; rd_size = 2'b11;
    ar_ready = 1'b1; r_valid = 1'b0; r_resp = 2'b00;
    got_rr = 0;
    for (int i = 0; i < 10 && got_rr == 0; i++) begin
      @(negedge clk);
      if (r_ready) got_rr = 1;
    end
    chk("rstR_reached", 64'(got_rr), 64'd1);
    rst = 1'b1; rd_addr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstR_arvalid", 64'(ar_valid), 64'd0);
    chk("rstR_rready", 64'(r_ready), 64'd0);
    chk("rstR_dvalid", 64'(rd_data_valid), 64'd0);
    chk("rstR_data", rd_data, 64'd0);
    chk("rstR_err", 64'(rd_err), 64'd0);
    chk("rstR_araddr", ar_addr, 64'd0);
    chk("rstR_arsize", 64'(ar_size), 64'd0);
    @(negedge clk);
    do_req("postrst", 64'h8000_0000, 2'b11, BEAT, 2'b00, 0, 0, BEAT, 1'b0, 3);

    // Request held across the pulse with a new address: one idle cycle between the two ARs.
    ar_tab = 8'b0001_0001;
    dv_tab = 8'b0100_0100;
    rd_addr_valid = 1'b1; rd_addr = 64'h8000_0100; rd_size = 2'b11;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = BEAT; r_resp = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_arvalid_c%0d", c), 64'(ar_valid), 64'(ar_tab[c-1]));
      chk($sformatf("b2b_dvalid_c%0d", c), 64'(rd_data_valid), 64'(dv_tab[c-1]));
      if (c == 1) chk("b2b_araddr1", ar_addr, 64'h8000_0100);
      if (c == 5) chk("b2b_araddr2", ar_addr, 64'h8000_0200);
      if (c == 3) rd_addr = 64'h8000_0200;
      if (c == 7) rd_addr_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
